// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the writeback stage (WB)
//   and the multi-cycle mul/div unit (MDU). Holds a scoreboard of MDU destinations
//   in flight and reports per-read-port busy flags to the hazard/stall logic.
//
//   Optional feature macro: RFWA_BYPASS_EN
//     defined   : adds fwd1_hit/fwd2_hit/fwd_data; a staged write no longer raises busy.
//     undefined : the staged write reports busy for its one staged cycle.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   wb_valid/wb_ready/wb_wn/wb_wd       WB write request handshake
//   mdu_valid/mdu_ready/mdu_wn/mdu_wd   MDU result handshake (valid held until accepted)
//   sb_set, sb_rn, sb_conflict   MDU issue marks destination pending; WAW advisory flag
//   RN1, RN2, busy1, busy2       register file read indices and their stall flags
//   fwd1_hit, fwd2_hit, fwd_data staged-write forwarding (RFWA_BYPASS_EN only)
//   RegWrite, WN, WD             registered register file write port
//
// State | meaning
//   WB_PRI  | WB owns the write port; MDU writes only when WB is idle
//   MDU_PRI | MDU starved too long; MDU owns the write port for one cycle
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_wn,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_wn,
    input  logic [DATA_W-1:0] mdu_wd,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_rn,
    output logic              sb_conflict,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    output logic              busy1,
    output logic              busy2,
`ifdef RFWA_BYPASS_EN
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WN,
    output logic [DATA_W-1:0] WD
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {WB_PRI = 1'b0, MDU_PRI = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt;
    logic [NREG-1:0]   sb_q;
    logic              wb_acc, mdu_acc, mdu_blocked;
    logic              staged_hit1, staged_hit2;

    assign wb_acc      = wb_valid & wb_ready;
    assign mdu_acc     = mdu_valid & mdu_ready;
    assign mdu_blocked = mdu_valid & ~mdu_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_PRI;
        else        state_q <= state_d;
    end

    // next state: MDU_PRI always lasts one cycle, since mdu_ready=1 there means the
    // MDU either gets accepted or has nothing pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_PRI:  if (mdu_blocked && starve_cnt == CNT_W'(STARVE_LIMIT - 1))
                         state_d = MDU_PRI;
            MDU_PRI: state_d = WB_PRI;
            default: state_d = WB_PRI;
        endcase
    end

    // outputs
    always_comb begin
        wb_ready  = 1'b1;
        mdu_ready = ~wb_valid;
        case (state_q)
            WB_PRI: begin
                wb_ready  = 1'b1;
                mdu_ready = ~wb_valid;
            end
            MDU_PRI: begin
                wb_ready  = ~mdu_valid;
                mdu_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           starve_cnt <= '0;
        else if (mdu_blocked) starve_cnt <= starve_cnt + 1'b1;
        else                  starve_cnt <= '0;
    end

    // Staging register. WN/WD follow any accepted write; a write to r0 completes
    // the handshake but never raises RegWrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite <= 1'b0;
            WN       <= '0;
            WD       <= '0;
        end else if (wb_acc) begin
            RegWrite <= (wb_wn != '0);
            WN       <= wb_wn;
            WD       <= wb_wd;
        end else if (mdu_acc) begin
            RegWrite <= (mdu_wn != '0);
            WN       <= mdu_wn;
            WD       <= mdu_wd;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    // Scoreboard: the set is written last so it wins over a same-index clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            if (mdu_acc)
                sb_q[mdu_wn] <= 1'b0;
            if (sb_set && sb_rn != '0)
                sb_q[sb_rn] <= 1'b1;
        end
    end

    assign sb_conflict = sb_set & (sb_rn != '0) & sb_q[sb_rn];

    assign staged_hit1 = RegWrite & (WN == RN1) & (RN1 != '0);
    assign staged_hit2 = RegWrite & (WN == RN2) & (RN2 != '0);

`ifdef RFWA_BYPASS_EN
    assign busy1    = (RN1 != '0) & sb_q[RN1];
    assign busy2    = (RN2 != '0) & sb_q[RN2];
    assign fwd1_hit = staged_hit1;
    assign fwd2_hit = staged_hit2;
    assign fwd_data = WD;
`else
    assign busy1 = ((RN1 != '0) & sb_q[RN1]) | staged_hit1;
    assign busy2 = ((RN2 != '0) & sb_q[RN2]) | staged_hit2;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LIMIT  = 4;
    localparam int NREG   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_valid, mdu_valid, sb_set;
    logic              wb_ready, mdu_ready, sb_conflict, busy1, busy2, RegWrite;
    logic [ADDR_W-1:0] wb_wn, mdu_wn, sb_rn, RN1, RN2, WN;
    logic [DATA_W-1:0] wb_wd, mdu_wd, WD;
`ifdef RFWA_BYPASS_EN
    logic              fwd1_hit, fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wn(wb_wn), .wb_wd(wb_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wn(mdu_wn), .mdu_wd(mdu_wd),
        .sb_set(sb_set), .sb_rn(sb_rn), .sb_conflict(sb_conflict),
        .RN1(RN1), .RN2(RN2), .busy1(busy1), .busy2(busy2),
`ifdef RFWA_BYPASS_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
        .RegWrite(RegWrite), .WN(WN), .WD(WD)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending set, staged write, and the length of the current
    // run of cycles in which the MDU was refused.
    bit              m_pend [NREG];
    bit              m_rw;
    bit [ADDR_W-1:0] m_wn;
    bit [DATA_W-1:0] m_wd;
    int              m_refused;
    bit              m_mdu_taken;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_rw = 0; m_wn = '0; m_wd = '0; m_refused = 0; m_mdu_taken = 0;
    endtask

    function automatic bit exp_busy(input logic [ADDR_W-1:0] rn);
        if (rn == '0) return 1'b0;
`ifdef RFWA_BYPASS_EN
        return m_pend[rn];
`else
        return m_pend[rn] || (m_rw && m_wn == rn);
`endif
    endfunction

    task automatic set_in(input bit wv, input int wn, input int wd, input bit mv, input int mn,
                          input int md, input bit ss, input int srn, input int r1, input int r2);
        wb_valid = wv;  wb_wn  = ADDR_W'(wn);  wb_wd  = DATA_W'(wd);
        mdu_valid = mv; mdu_wn = ADDR_W'(mn);  mdu_wd = DATA_W'(md);
        sb_set = ss;    sb_rn  = ADDR_W'(srn);
        RN1 = ADDR_W'(r1); RN2 = ADDR_W'(r2);
    endtask

    // One clock: check combinational outputs, clock, advance the model, check registers.
    task automatic cycle();
        bit prio, e_wr, e_mr, wacc, macc;
        prio = (m_refused >= LIMIT);
        e_wr = prio ? !mdu_valid : 1'b1;
        e_mr = prio ? 1'b1 : !wb_valid;
        #1;
        chk("wb_ready", wb_ready, e_wr);
        chk("mdu_ready", mdu_ready, e_mr);
        chk("busy1", busy1, exp_busy(RN1));
        chk("busy2", busy2, exp_busy(RN2));
        chk("sb_conflict", sb_conflict, sb_set && sb_rn != 0 && m_pend[sb_rn]);
`ifdef RFWA_BYPASS_EN
        chk("fwd1_hit", fwd1_hit, m_rw && m_wn == RN1 && RN1 != 0);
        chk("fwd2_hit", fwd2_hit, m_rw && m_wn == RN2 && RN2 != 0);
        chk("fwd_data", fwd_data, m_wd);
`endif
        wacc = wb_valid && e_wr;
        macc = mdu_valid && e_mr;
        @(posedge clk);
        if (wacc)      begin m_rw = (wb_wn != 0);  m_wn = wb_wn;  m_wd = wb_wd;  end
        else if (macc) begin m_rw = (mdu_wn != 0); m_wn = mdu_wn; m_wd = mdu_wd; end
        else           m_rw = 0;
        if (macc) m_pend[mdu_wn] = 1'b0;
        if (sb_set && sb_rn != 0) m_pend[sb_rn] = 1'b1;
        m_refused   = (mdu_valid && !e_mr) ? m_refused + 1 : 0;
        m_mdu_taken = macc;
        #1;
        chk("RegWrite", RegWrite, m_rw);
        chk("WN", WN, m_wn);
        chk("WD", WD, m_wd);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_WN", WN, 0);
        chk("rst_WD", WD, 0);
        chk("rst_wb_ready", wb_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous WB r3 / MDU r5: WB wins, MDU refused 4 cycles, then takes the port.
        set_in(1, 3, 'h11, 1, 5, 'h22, 0, 0, 0, 0);
        cycle();
        chk("t2_first_WN", WN, 3);
        chk("t2_first_WD", WD, 'h11);
        cycle(); cycle(); cycle();
        chk("t2_mdu_ready", mdu_ready, 1);
        chk("t2_wb_ready", wb_ready, 0);
        cycle();
        chk("t2_stage_RegWrite", RegWrite, 1);
        chk("t2_stage_WN", WN, 5);
        chk("t2_stage_WD", WD, 'h22);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Scoreboard r7, then simultaneous clear+set keeps it busy.
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        #1 chk("t3_busy_after_set", busy1, 1);
        cycle();
        set_in(0, 0, 0, 1, 7, 'h77, 1, 7, 7, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        cycle();
        chk("t3_busy_set_wins", busy1, 1);
        set_in(0, 0, 0, 1, 7, 'h78, 0, 0, 7, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        cycle();
        chk("t3_busy_cleared", busy1, 0);

        // r0 handling.
        set_in(1, 0, 'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t4_r0_RegWrite", RegWrite, 0);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1 chk("t4_r0_busy1", busy1, 0);
        chk("t4_r0_conflict", sb_conflict, 0);
        cycle();

        // Staged hit on r9.
        set_in(1, 9, 'hABCD, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
`ifdef RFWA_BYPASS_EN
        #1 chk("t5_busy2", busy2, 0);
        chk("t5_fwd2_hit", fwd2_hit, 1);
        chk("t5_fwd_data", fwd_data, 'hABCD);
`else
        #1 chk("t5_busy2", busy2, 1);
`endif
        cycle();
        chk("t5_busy2_after", busy2, 0);

        // WAW on r4.
        set_in(0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        #1 chk("t6_conflict", sb_conflict, 1);
        cycle();

        // Randomized traffic; MDU results held until accepted.
        mdu_valid = 0;
        for (int i = 0; i < 400; i++) begin
            wb_valid = ($urandom_range(0, 9) < 7);
            wb_wn    = ADDR_W'($urandom_range(0, 7));
            wb_wd    = DATA_W'($urandom);
            if (!mdu_valid && $urandom_range(0, 9) < 5) begin
                mdu_valid = 1;
                mdu_wn    = ADDR_W'($urandom_range(0, 7));
                mdu_wd    = DATA_W'($urandom);
            end
            sb_set = ($urandom_range(0, 9) < 3);
            sb_rn  = ADDR_W'($urandom_range(0, 7));
            RN1    = ADDR_W'($urandom_range(0, 7));
            RN2    = ADDR_W'($urandom_range(0, 7));
            cycle();
            if (m_mdu_taken) mdu_valid = 0;
        end

        // Reset mid-stream with a staged write.
        set_in(1, 3, 'h33, 0, 0, 0, 0, 0, 3, 3);
        cycle();
        chk("t1_pre_RegWrite", RegWrite, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_RegWrite", RegWrite, 0);
        chk("t1_WN", WN, 0);
        chk("t1_WD", WD, 0);
        chk("t1_busy1", busy1, 0);
        chk("t1_busy2", busy2, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_in(1, 6, 'h66, 1, 2, 'h2, 0, 0, 6, 2);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
